// File: rtl/fir_alu.sv
// fir_alu: arithmetic unit of the FIR core.
// Two fixed pipeline stages: operands and opcode are registered first, then
// the selected operation updates the registered result (which doubles as the
// accumulator). Nothing in the result path is combinational from the ports.
module fir_alu #(
  parameter int DATA_W = 16,
  parameter int RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        op_sel,
  output logic [RES_W-1:0]  result
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_MUL = 2'b01,
    OP_MAC = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  // Stage-1 registers (operands kept signed so widening sign-extends)
  logic signed [DATA_W-1:0]   a_q;
  logic signed [DATA_W-1:0]   b_q;
  op_e                        op_q;

  // Stage-2 register: the result is also the accumulator
  logic [RES_W-1:0]           result_q;
  logic [RES_W-1:0]           result_d;

  // Datapath intermediates
  logic signed [RES_W-1:0]    sum_ext;
  logic signed [2*DATA_W-1:0] prod_full;
  logic signed [RES_W-1:0]    prod_ext;

  // Stage 1: capture operands and opcode on every edge, no enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_ADD;
    end else begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op_e'(op_sel);
    end
  end

  // Arithmetic on the stage-1 values: exact sum and exact full-width product
  always_comb begin
    sum_ext   = RES_W'(a_q) + RES_W'(b_q);
    prod_full = (2*DATA_W)'(a_q) * (2*DATA_W)'(b_q);
    prod_ext  = RES_W'(prod_full);
  end

  // Stage-2 next value; MAC wraps modulo 2^RES_W with no saturation
  always_comb begin
    result_d = result_q;
    case (op_q)
      OP_ADD:  result_d = $unsigned(sum_ext);
      OP_MUL:  result_d = $unsigned(prod_ext);
      OP_MAC:  result_d = result_q + $unsigned(prod_ext);
      OP_CLR:  result_d = '0;
      default: result_d = result_q;
    endcase
  end

  // Stage 2: result register, cleared asynchronously with the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_fir_alu.sv
// tb_fir_alu: directed bench for fir_alu with a reference model and
// hand-computed spot checks.
module tb_fir_alu;

  localparam int DATA_W = 16;
  localparam int RES_W  = 32;

  logic              clk;
  logic              rst;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [1:0]        op_sel;
  logic [RES_W-1:0]  result;

  int n_checks = 0;
  int n_fail   = 0;

  fir_alu #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .op_sel (op_sel),
    .result (result)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Operands the unit has latched, as plain integers, and the expected result.
  int          m_a   = 0;
  int          m_b   = 0;
  int          m_op  = 0;
  logic [31:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_a   = 0;
      m_b   = 0;
      m_op  = 0;
      m_res = '0;
    end else begin
      case (m_op)
        0: m_res = 32'(m_a + m_b);
        1: m_res = 32'(m_a * m_b);
        2: m_res = m_res + 32'(m_a * m_b);
        default: m_res = '0;
      endcase
      m_a  = int'($signed(a));
      m_b  = int'($signed(b));
      m_op = int'(op_sel);
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    n_checks++;
    if (result !== m_res) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t result=0x%08h expected=0x%08h", $time, result, m_res);
    end
  end

  // ---------------- driver tasks ----------------
  // Apply one vector at the falling edge and advance to the next falling edge.
  task automatic cyc(input int av, input int bv, input logic [1:0] op);
    a      = 16'(av);
    b      = 16'(bv);
    op_sel = op;
    @(negedge clk);
  endtask

  // Hand-computed literal expectation.
  task automatic expect_lit(input string name, input logic [31:0] exp);
    n_checks++;
    if (result !== exp) begin
      n_fail++;
      $display("FAIL %s result=0x%08h expected=0x%08h", name, result, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    op_sel = 2'b00;
    @(negedge clk);
    @(negedge clk);
    expect_lit("reset_value", 32'h0000_0000);
    rst = 1'b0;

    // Add
    cyc(100, -3, 2'b00);
    cyc(100, -3, 2'b00);
    expect_lit("add_97", 32'h0000_0061);
    cyc(100, -3, 2'b00);
    expect_lit("add_97_hold", 32'h0000_0061);
    cyc(-32768, -32768, 2'b00);
    cyc(-32768, -32768, 2'b00);
    expect_lit("add_min_min", 32'hFFFF_0000);
    cyc(32767, 32767, 2'b00);
    cyc(32767, 32767, 2'b00);
    expect_lit("add_max_max", 32'h0000_FFFE);

    // Multiply
    cyc(-300, 200, 2'b01);
    cyc(-300, 200, 2'b01);
    expect_lit("mul_neg", 32'hFFFF_15A0);
    cyc(-32768, -32768, 2'b01);
    cyc(-32768, -32768, 2'b01);
    expect_lit("mul_min_min", 32'h4000_0000);
    cyc(0, 12345, 2'b01);
    cyc(0, 12345, 2'b01);
    expect_lit("mul_zero", 32'h0000_0000);

    // Latency
    cyc(5, 1, 2'b00);
    cyc(5, 1, 2'b00);
    expect_lit("lat_old", 32'd6);
    cyc(7, 1, 2'b00);
    expect_lit("lat_edge_n", 32'd6);
    cyc(7, 1, 2'b00);
    expect_lit("lat_edge_n1", 32'd8);

    // MAC from clear
    cyc(0, 0, 2'b11);
    cyc(0, 0, 2'b11);
    expect_lit("clr", 32'd0);
    cyc(3, 4, 2'b10);
    expect_lit("mac_start", 32'd0);
    cyc(3, 4, 2'b10);
    expect_lit("mac_12", 32'd12);
    cyc(3, 4, 2'b10);
    expect_lit("mac_24", 32'd24);
    cyc(3, 4, 2'b10);
    expect_lit("mac_36", 32'd36);
    cyc(0, 0, 2'b11);
    expect_lit("mac_48_before_clr", 32'd48);
    cyc(0, 0, 2'b11);
    expect_lit("clr_two_edges", 32'd0);

    // MAC wrap
    cyc(-32768, -32768, 2'b01);
    cyc(-32768, -32768, 2'b01);
    expect_lit("wrap_preload", 32'h4000_0000);
    cyc(-32768, -32768, 2'b10);
    expect_lit("wrap_first", 32'h4000_0000);
    cyc(-32768, -32768, 2'b10);
    expect_lit("wrap_8", 32'h8000_0000);
    cyc(-32768, -32768, 2'b10);
    expect_lit("wrap_c", 32'hC000_0000);
    cyc(-32768, -32768, 2'b10);
    expect_lit("wrap_0", 32'h0000_0000);
    cyc(-32768, -32768, 2'b10);
    expect_lit("wrap_4", 32'h4000_0000);

    // Asynchronous reset during MAC
    cyc(3, 4, 2'b10);
    cyc(3, 4, 2'b10);
    #2;
    rst = 1'b1;
    #1;
    expect_lit("async_rst", 32'h0000_0000);
    @(negedge clk);
    cyc(3, 4, 2'b10);
    expect_lit("rst_hold", 32'h0000_0000);
    rst = 1'b0;
    cyc(2, 3, 2'b01);
    expect_lit("rst_release_1st", 32'h0000_0000);
    cyc(2, 3, 2'b01);
    expect_lit("rst_release_2nd", 32'd6);

    cyc(0, 0, 2'b11);
    cyc(0, 0, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
